// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with byte-lane write strobes, registered read ports,
// same-address write/read bypass, out-of-range detection and exported low registers.
module reg_file_2r1w #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int NUM_EXPORT = 4,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        WrEn,
    input  logic [AW-1:0]               WrAddr,
    input  logic [WIDTH-1:0]            WrData,
    input  logic [WIDTH/8-1:0]          WrMask,
    input  logic                        RdEnA,
    input  logic [AW-1:0]               RdAddrA,
    input  logic                        RdEnB,
    input  logic [AW-1:0]               RdAddrB,
    output logic [WIDTH-1:0]            RdDataA,
    output logic [WIDTH-1:0]            RdDataB,
    output logic                        RdValidA,
    output logic                        RdValidB,
    output logic                        AddrErr,
    output logic [NUM_EXPORT*WIDTH-1:0] REGS_OUT
);

    localparam int LANES = WIDTH / 8;
    // One extra bit so DEPTH == 2**AW is still representable.
    localparam logic [AW:0] DEPTH_LIM = DEPTH[AW:0];

    logic [WIDTH-1:0] regs [DEPTH];

    logic             wr_oor;
    logic             wr_hit;
    logic             wr_err;
    logic [WIDTH-1:0] wr_merged;

    logic             rd_oor_a;
    logic             rd_oor_b;
    logic             rd_err_a;
    logic             rd_err_b;
    logic [WIDTH-1:0] rd_next_a;
    logic [WIDTH-1:0] rd_next_b;

    function automatic logic [WIDTH-1:0] merge_lanes(
        input logic [WIDTH-1:0] old_val,
        input logic [WIDTH-1:0] new_val,
        input logic [LANES-1:0] mask
    );
        logic [WIDTH-1:0] result;
        result = old_val;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return result;
    endfunction

    assign wr_oor    = ({1'b0, WrAddr} >= DEPTH_LIM);
    assign wr_hit    = WrEn && !wr_oor;
    assign wr_err    = WrEn && wr_oor;
    assign wr_merged = merge_lanes(regs[WrAddr], WrData, WrMask);

    assign rd_oor_a  = ({1'b0, RdAddrA} >= DEPTH_LIM);
    assign rd_oor_b  = ({1'b0, RdAddrB} >= DEPTH_LIM);
    assign rd_err_a  = RdEnA && rd_oor_a;
    assign rd_err_b  = RdEnB && rd_oor_b;

    // Out-of-range reads return zero; a colliding in-range write is forwarded only with BYPASS.
    always_comb begin
        rd_next_a = '0;
        if (!rd_oor_a) begin
            if (BYPASS && wr_hit && (RdAddrA == WrAddr)) begin
                rd_next_a = wr_merged;
            end else begin
                rd_next_a = regs[RdAddrA];
            end
        end
    end

    always_comb begin
        rd_next_b = '0;
        if (!rd_oor_b) begin
            if (BYPASS && wr_hit && (RdAddrB == WrAddr)) begin
                rd_next_b = wr_merged;
            end else begin
                rd_next_b = regs[RdAddrB];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            RdDataA  <= '0;
            RdDataB  <= '0;
            RdValidA <= 1'b0;
            RdValidB <= 1'b0;
            AddrErr  <= 1'b0;
        end else begin
            if (wr_hit) begin
                regs[WrAddr] <= wr_merged;
            end
            if (RdEnA) begin
                RdDataA <= rd_next_a;
            end
            if (RdEnB) begin
                RdDataB <= rd_next_b;
            end
            RdValidA <= RdEnA;
            RdValidB <= RdEnB;
            AddrErr  <= wr_err || rd_err_a || rd_err_b;
        end
    end

    for (genvar k = 0; k < NUM_EXPORT; k++) begin : g_export
        assign REGS_OUT[k*WIDTH +: WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: WIDTH=16, DEPTH=12, with a BYPASS=1 and a BYPASS=0
// instance sharing the same stimulus so collisions can be compared side by side.
module tb_reg_file_2r1w;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_mask;
    logic        rd_en_a;
    logic [3:0]  rd_addr_a;
    logic        rd_en_b;
    logic [3:0]  rd_addr_b;

    logic [15:0] rd_data_a, rd_data_b, rd_data_a_nb, rd_data_b_nb;
    logic        rd_valid_a, rd_valid_b, rd_valid_a_nb, rd_valid_b_nb;
    logic        addr_err, addr_err_nb;
    logic [63:0] regs_out, regs_out_nb;

    int num_checks = 0;
    int num_fails  = 0;

    reg_file_2r1w #(.WIDTH(16), .DEPTH(12), .AW(4), .NUM_EXPORT(4), .BYPASS(1'b1)) dut (
        .CLK(clk), .RST(rst), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrMask(wr_mask),
        .RdEnA(rd_en_a), .RdAddrA(rd_addr_a), .RdEnB(rd_en_b), .RdAddrB(rd_addr_b),
        .RdDataA(rd_data_a), .RdDataB(rd_data_b), .RdValidA(rd_valid_a), .RdValidB(rd_valid_b),
        .AddrErr(addr_err), .REGS_OUT(regs_out)
    );

    reg_file_2r1w #(.WIDTH(16), .DEPTH(12), .AW(4), .NUM_EXPORT(4), .BYPASS(1'b0)) dut_nb (
        .CLK(clk), .RST(rst), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrMask(wr_mask),
        .RdEnA(rd_en_a), .RdAddrA(rd_addr_a), .RdEnB(rd_en_b), .RdAddrB(rd_addr_b),
        .RdDataA(rd_data_a_nb), .RdDataB(rd_data_b_nb), .RdValidA(rd_valid_a_nb), .RdValidB(rd_valid_b_nb),
        .AddrErr(addr_err_nb), .REGS_OUT(regs_out_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of requests, clock it in, then settle just past the edge.
    task automatic applyStimulus(
        input logic we, input logic [3:0] wa, input logic [15:0] wd, input logic [1:0] wm,
        input logic rea, input logic [3:0] raa, input logic reb, input logic [3:0] rab
    );
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        wr_mask   = wm;
        rd_en_a   = rea;
        rd_addr_a = raa;
        rd_en_b   = reb;
        rd_addr_b = rab;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;

        // Populate some state so the reset checks are meaningful
        applyStimulus(1'b1, 4'd0, 16'h1111, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0);
        checkOutput("pre_reset_reg0", regs_out[15:0], 64'h1111);
        applyStimulus(1'b1, 4'd1, 16'h2222, 2'b11, 1'b1, 4'd0, 1'b0, 4'd0);
        checkOutput("pre_reset_rd_a", rd_data_a, 64'h1111);

        // Reset wins over concurrent write and reads
        rst = 1'b1;
        applyStimulus(1'b1, 4'd2, 16'h3333, 2'b11, 1'b1, 4'd0, 1'b1, 4'd0);
        applyStimulus(1'b1, 4'd2, 16'h3333, 2'b11, 1'b1, 4'd0, 1'b1, 4'd0);
        checkOutput("reset_regs_out", regs_out, 64'h0);
        checkOutput("reset_rd_data_a", rd_data_a, 64'h0);
        checkOutput("reset_rd_data_b", rd_data_b, 64'h0);
        checkOutput("reset_rd_valid_a", rd_valid_a, 64'h0);
        checkOutput("reset_rd_valid_b", rd_valid_b, 64'h0);
        checkOutput("reset_addr_err", addr_err, 64'h0);
        rst = 1'b0;

        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5, 1'b0, 4'd0);
        checkOutput("post_reset_rd5", rd_data_a, 64'h0);
        checkOutput("post_reset_valid_a", rd_valid_a, 64'h1);
        checkOutput("post_reset_valid_b", rd_valid_b, 64'h0);

        // Basic write / read with a one-cycle valid pulse
        applyStimulus(1'b1, 4'd5, 16'h000A, 2'b01, 1'b0, 4'd0, 1'b0, 4'd0);
        checkOutput("valid_a_pulse_end", rd_valid_a, 64'h0);
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5, 1'b0, 4'd0);
        checkOutput("basic_rd_a", rd_data_a, 64'h000A);
        checkOutput("basic_valid_a", rd_valid_a, 64'h1);
        idle();
        checkOutput("basic_valid_a_low", rd_valid_a, 64'h0);
        checkOutput("basic_rd_a_hold", rd_data_a, 64'h000A);

        applyStimulus(1'b1, 4'd2, 16'h0003, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 1'b1, 4'd2);
        checkOutput("basic_rd_b", rd_data_b, 64'h0003);
        checkOutput("basic_valid_b", rd_valid_b, 64'h1);
        checkOutput("export_reg2", regs_out[47:32], 64'h0003);

        // Byte-lane mask
        applyStimulus(1'b1, 4'd1, 16'hFFFF, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0);
        applyStimulus(1'b1, 4'd1, 16'h1234, 2'b01, 1'b0, 4'd0, 1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd1, 1'b0, 4'd0);
        checkOutput("mask_rd_a", rd_data_a, 64'hFF34);
        checkOutput("mask_export_reg1", regs_out[31:16], 64'hFF34);

        // Collisions: full write on port A, upper-lane-only write on port B
        applyStimulus(1'b1, 4'd3, 16'h0055, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0);
        applyStimulus(1'b1, 4'd3, 16'h00AA, 2'b11, 1'b1, 4'd3, 1'b0, 4'd0);
        checkOutput("coll_bypass_a", rd_data_a, 64'h00AA);
        checkOutput("coll_nobypass_a", rd_data_a_nb, 64'h0055);
        applyStimulus(1'b1, 4'd3, 16'h7700, 2'b10, 1'b0, 4'd0, 1'b1, 4'd3);
        checkOutput("coll_bypass_merge_b", rd_data_b, 64'h77AA);
        checkOutput("coll_nobypass_merge_b", rd_data_b_nb, 64'h00AA);
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3, 1'b0, 4'd0);
        checkOutput("coll_after_a", rd_data_a, 64'h77AA);
        checkOutput("coll_after_a_nb", rd_data_a_nb, 64'h77AA);

        // Zero mask: no change, no error
        applyStimulus(1'b1, 4'd0, 16'hFFFF, 2'b00, 1'b0, 4'd0, 1'b0, 4'd0);
        checkOutput("mask0_no_err", addr_err, 64'h0);
        checkOutput("mask0_reg0", regs_out[15:0], 64'h0);

        // Last valid address, then out-of-range writes
        applyStimulus(1'b1, 4'd11, 16'hBEEF, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0);
        checkOutput("addr11_no_err", addr_err, 64'h0);
        applyStimulus(1'b1, 4'd13, 16'h0077, 2'b11, 1'b1, 4'd11, 1'b0, 4'd0);
        checkOutput("oor_wr13_err", addr_err, 64'h1);
        checkOutput("oor_wr13_regs", regs_out, 64'h77AA_0003_FF34_0000);
        checkOutput("addr11_rd_a", rd_data_a, 64'hBEEF);
        applyStimulus(1'b1, 4'd12, 16'h0077, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0);
        checkOutput("oor_wr12_err", addr_err, 64'h1);
        idle();
        checkOutput("oor_err_pulse_end", addr_err, 64'h0);
        checkOutput("oor_regs_unchanged", regs_out_nb, 64'h77AA_0003_FF34_0000);

        // Out-of-range reads on both ports
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd14, 1'b1, 4'd12);
        checkOutput("oor_rd_a_data", rd_data_a, 64'h0);
        checkOutput("oor_rd_a_valid", rd_valid_a, 64'h1);
        checkOutput("oor_rd_b_data", rd_data_b, 64'h0);
        checkOutput("oor_rd_b_valid", rd_valid_b, 64'h1);
        checkOutput("oor_rd_err", addr_err, 64'h1);

        // Both ports on the same address
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2, 1'b1, 4'd2);
        checkOutput("dual_rd_a", rd_data_a, 64'h0003);
        checkOutput("dual_rd_b", rd_data_b, 64'h0003);
        checkOutput("dual_valid", {rd_valid_a, rd_valid_b}, 64'h3);
        checkOutput("dual_no_err", addr_err, 64'h0);

        // Back-to-back reads keep valid high while data changes
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd1, 1'b0, 4'd0);
        checkOutput("b2b_first", rd_data_a, 64'hFF34);
        applyStimulus(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3, 1'b0, 4'd0);
        checkOutput("b2b_second", rd_data_a, 64'h77AA);
        checkOutput("b2b_valid", rd_valid_a, 64'h1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
